// File: rtl/id_ex_reg.sv
// ============================================================================
// Module   : id_ex_reg
// Brief    : ID/EX pipeline register with freeze, bubble and flush handling.
//            Optional saturating NOP counter enabled by ID_EX_BUBBLE_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module id_ex_reg #(
  parameter int DATA_W = 32
`ifdef ID_EX_BUBBLE_CNT_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              freeze_in,
  input  logic              flush_in,
  input  logic              bubble_in,
  input  logic              wb_en_in,
  input  logic              mem_r_en_in,
  input  logic              mem_w_en_in,
  input  logic              b_in,
  input  logic              s_in,
  input  logic [3:0]        exe_cmd_in,
  input  logic              imm_in,
  input  logic [DATA_W-1:0] pc_in,
  input  logic [DATA_W-1:0] val_rn_in,
  input  logic [DATA_W-1:0] val_rm_in,
  input  logic [11:0]       shift_operand_in,
  input  logic [23:0]       signed_imm24_in,
  input  logic [3:0]        dest_in,
  input  logic [3:0]        src1_in,
  input  logic [3:0]        src2_in,
  input  logic [3:0]        status_in,
  output logic              wb_en_out,
  output logic              mem_r_en_out,
  output logic              mem_w_en_out,
  output logic              b_out,
  output logic              s_out,
  output logic [3:0]        exe_cmd_out,
  output logic              imm_out,
  output logic [DATA_W-1:0] pc_out,
  output logic [DATA_W-1:0] val_rn_out,
  output logic [DATA_W-1:0] val_rm_out,
  output logic [11:0]       shift_operand_out,
  output logic [23:0]       signed_imm24_out,
  output logic [3:0]        dest_out,
  output logic [3:0]        src1_out,
  output logic [3:0]        src2_out,
  output logic [3:0]        status_out,
  output logic              valid_out
`ifdef ID_EX_BUBBLE_CNT_EN
  , output logic [CNT_W-1:0] bubble_cnt_out
`endif
);

  typedef struct packed {
    logic              wb_en;
    logic              mem_r_en;
    logic              mem_w_en;
    logic              b;
    logic              s;
    logic [3:0]        exe_cmd;
    logic              imm;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] val_rn;
    logic [DATA_W-1:0] val_rm;
    logic [11:0]       shift_operand;
    logic [23:0]       signed_imm24;
    logic [3:0]        dest;
    logic [3:0]        src1;
    logic [3:0]        src2;
    logic [3:0]        status;
  } stage_t;

  stage_t w_stage_in;
  stage_t r_stage;
  logic   r_valid;
  logic   w_nop;

  assign w_stage_in = '{
    wb_en:         wb_en_in,
    mem_r_en:      mem_r_en_in,
    mem_w_en:      mem_w_en_in,
    b:             b_in,
    s:             s_in,
    exe_cmd:       exe_cmd_in,
    imm:           imm_in,
    pc:            pc_in,
    val_rn:        val_rn_in,
    val_rm:        val_rm_in,
    shift_operand: shift_operand_in,
    signed_imm24:  signed_imm24_in,
    dest:          dest_in,
    src1:          src1_in,
    src2:          src2_in,
    status:        status_in
  };

  assign w_nop = flush_in | bubble_in;

  // A NOP clears every field, data included, so nothing stale reaches EX.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_stage <= '0;
      r_valid <= 1'b0;
    end else if (!freeze_in) begin
      if (w_nop) begin
        r_stage <= '0;
        r_valid <= 1'b0;
      end else begin
        r_stage <= w_stage_in;
        r_valid <= 1'b1;
      end
    end
  end

  assign wb_en_out         = r_stage.wb_en;
  assign mem_r_en_out      = r_stage.mem_r_en;
  assign mem_w_en_out      = r_stage.mem_w_en;
  assign b_out             = r_stage.b;
  assign s_out             = r_stage.s;
  assign exe_cmd_out       = r_stage.exe_cmd;
  assign imm_out           = r_stage.imm;
  assign pc_out            = r_stage.pc;
  assign val_rn_out        = r_stage.val_rn;
  assign val_rm_out        = r_stage.val_rm;
  assign shift_operand_out = r_stage.shift_operand;
  assign signed_imm24_out  = r_stage.signed_imm24;
  assign dest_out          = r_stage.dest;
  assign src1_out          = r_stage.src1;
  assign src2_out          = r_stage.src2;
  assign status_out        = r_stage.status;
  assign valid_out         = r_valid;

`ifdef ID_EX_BUBBLE_CNT_EN
  localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] r_bubble_cnt;

  // Saturating; only reset clears it.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_bubble_cnt <= '0;
    end else if (!freeze_in && w_nop && (r_bubble_cnt != {CNT_W{1'b1}})) begin
      r_bubble_cnt <= r_bubble_cnt + C_CNT_ONE;
    end
  end

  assign bubble_cnt_out = r_bubble_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_id_ex_reg.sv
// ============================================================================
// Module   : tb_id_ex_reg
// Brief    : Scoreboard bench for id_ex_reg; counter checks with ID_EX_BUBBLE_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_id_ex_reg;

  localparam int C_DATA_W = 32;
  localparam int C_CNT_W  = 2;

  typedef struct packed {
    logic        wb_en, mem_r_en, mem_w_en, b, s;
    logic [3:0]  exe_cmd;
    logic        imm;
    logic [31:0] pc, val_rn, val_rm;
    logic [11:0] shift_operand;
    logic [23:0] signed_imm24;
    logic [3:0]  dest, src1, src2, status;
    logic        valid;
  } obs_t;

  typedef struct {
    obs_t  o;
    int    cnt;
    string tag;
  } exp_t;

  logic clk_in = 1'b0;
  logic rst_n_in = 1'b0;
  logic freeze_in = 1'b0, flush_in = 1'b0, bubble_in = 1'b0;
  logic wb_en_in = 1'b0, mem_r_en_in = 1'b0, mem_w_en_in = 1'b0, b_in = 1'b0, s_in = 1'b0;
  logic [3:0]  exe_cmd_in = '0;
  logic        imm_in = 1'b0;
  logic [31:0] pc_in = '0, val_rn_in = '0, val_rm_in = '0;
  logic [11:0] shift_operand_in = '0;
  logic [23:0] signed_imm24_in = '0;
  logic [3:0]  dest_in = '0, src1_in = '0, src2_in = '0, status_in = '0;

  logic        wb_en_out, mem_r_en_out, mem_w_en_out, b_out, s_out;
  logic [3:0]  exe_cmd_out;
  logic        imm_out;
  logic [31:0] pc_out, val_rn_out, val_rm_out;
  logic [11:0] shift_operand_out;
  logic [23:0] signed_imm24_out;
  logic [3:0]  dest_out, src1_out, src2_out, status_out;
  logic        valid_out;
`ifdef ID_EX_BUBBLE_CNT_EN
  logic [C_CNT_W-1:0] bubble_cnt_out;
`endif

  id_ex_reg #(
    .DATA_W(C_DATA_W)
`ifdef ID_EX_BUBBLE_CNT_EN
    , .CNT_W(C_CNT_W)
`endif
  ) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in),
    .freeze_in(freeze_in), .flush_in(flush_in), .bubble_in(bubble_in),
    .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in),
    .b_in(b_in), .s_in(s_in), .exe_cmd_in(exe_cmd_in), .imm_in(imm_in),
    .pc_in(pc_in), .val_rn_in(val_rn_in), .val_rm_in(val_rm_in),
    .shift_operand_in(shift_operand_in), .signed_imm24_in(signed_imm24_in),
    .dest_in(dest_in), .src1_in(src1_in), .src2_in(src2_in), .status_in(status_in),
    .wb_en_out(wb_en_out), .mem_r_en_out(mem_r_en_out), .mem_w_en_out(mem_w_en_out),
    .b_out(b_out), .s_out(s_out), .exe_cmd_out(exe_cmd_out), .imm_out(imm_out),
    .pc_out(pc_out), .val_rn_out(val_rn_out), .val_rm_out(val_rm_out),
    .shift_operand_out(shift_operand_out), .signed_imm24_out(signed_imm24_out),
    .dest_out(dest_out), .src1_out(src1_out), .src2_out(src2_out), .status_out(status_out),
    .valid_out(valid_out)
`ifdef ID_EX_BUBBLE_CNT_EN
    , .bubble_cnt_out(bubble_cnt_out)
`endif
  );

  always #5 clk_in = ~clk_in;

  int   total = 0;
  int   bad = 0;
  exp_t sb_q[$];
  obs_t model_st = '0;
  int   model_cnt = 0;
  localparam int C_CNT_MAX = (1 << C_CNT_W) - 1;

  function automatic obs_t sample();
    obs_t a;
    a.wb_en = wb_en_out; a.mem_r_en = mem_r_en_out; a.mem_w_en = mem_w_en_out;
    a.b = b_out; a.s = s_out; a.exe_cmd = exe_cmd_out; a.imm = imm_out;
    a.pc = pc_out; a.val_rn = val_rn_out; a.val_rm = val_rm_out;
    a.shift_operand = shift_operand_out; a.signed_imm24 = signed_imm24_out;
    a.dest = dest_out; a.src1 = src1_out; a.src2 = src2_out; a.status = status_out;
    a.valid = valid_out;
    return a;
  endfunction

  function automatic int sample_cnt();
`ifdef ID_EX_BUBBLE_CNT_EN
    return int'(bubble_cnt_out);
`else
    return 0;
`endif
  endfunction

  function automatic obs_t rnd_fields();
    obs_t d;
    d = {$urandom, $urandom, $urandom, $urandom, $urandom};
    d.valid = 1'b0;
    return d;
  endfunction

  task automatic check(input string tag, input obs_t exp_o, input int exp_cnt);
    obs_t a;
    int   c;
    a = sample();
    c = sample_cnt();
    total++;
    if (a !== exp_o || c != exp_cnt) begin
      bad++;
      $display("FAIL %s got=%h cnt=%0d exp=%h cnt=%0d", tag, a, c, exp_o, exp_cnt);
    end
  endtask

  // Reference: freeze holds, flush/bubble yields an all-zero NOP, else load.
  task automatic step(input string tag, input logic fr, input logic fl,
                      input logic bu, input obs_t d);
    exp_t e;
    @(negedge clk_in);
    freeze_in = fr; flush_in = fl; bubble_in = bu;
    wb_en_in = d.wb_en; mem_r_en_in = d.mem_r_en; mem_w_en_in = d.mem_w_en;
    b_in = d.b; s_in = d.s; exe_cmd_in = d.exe_cmd; imm_in = d.imm;
    pc_in = d.pc; val_rn_in = d.val_rn; val_rm_in = d.val_rm;
    shift_operand_in = d.shift_operand; signed_imm24_in = d.signed_imm24;
    dest_in = d.dest; src1_in = d.src1; src2_in = d.src2; status_in = d.status;
    if (!fr) begin
      if (fl || bu) begin
        model_st = '0;
`ifdef ID_EX_BUBBLE_CNT_EN
        if (model_cnt < C_CNT_MAX) model_cnt = model_cnt + 1;
`endif
      end else begin
        model_st = d;
        model_st.valid = 1'b1;
      end
    end
    e.o = model_st;
    e.cnt = model_cnt;
    e.tag = tag;
    sb_q.push_back(e);
  endtask

  // Monitor: one expected entry per capturing edge.
  always @(posedge clk_in) begin
    #1;
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      check(e.tag, e.o, e.cnt);
    end
  end

  task automatic drain();
    int budget;
    budget = 10;
    while (sb_q.size() > 0 && budget > 0) begin
      @(posedge clk_in); #2;
      budget--;
    end
    if (sb_q.size() > 0) begin
      total++; bad++;
      $display("FAIL drain got=%0d pending exp=0", sb_q.size());
      sb_q.delete();
    end
  endtask

  initial begin
    obs_t d;
    obs_t zero;
    zero = '0;

    // Reset with nonzero inputs: outputs stay clear.
    d = rnd_fields(); d.dest = 4'hA; d.wb_en = 1'b1;
    wb_en_in = 1'b1; dest_in = 4'hA; val_rn_in = 32'hFFFF_FFFF; pc_in = 32'h44;
    repeat (3) @(posedge clk_in);
    #2 check("reset_hold", zero, 0);
    @(posedge clk_in); #2 rst_n_in = 1'b1;
    step("reset_release", 1'b0, 1'b0, 1'b0, d);
    drain();

    // Load
    d = rnd_fields(); d.val_rn = 32'h1234_5678; d.src1 = 4'd3; d.exe_cmd = 4'b0010;
    step("load", 1'b0, 1'b0, 1'b0, d);

    // Freeze for 3 cycles while inputs change and flush is pending
    d = rnd_fields(); d.dest = 4'd5;
    step("freeze_pre", 1'b0, 1'b0, 1'b0, d);
    for (int i = 0; i < 3; i++) step("freeze_hold", 1'b1, 1'b1, 1'b0, rnd_fields());
    step("freeze_flush", 1'b0, 1'b1, 1'b0, rnd_fields());

    // Bubble then normal load
    d = rnd_fields(); d.wb_en = 1'b1; d.dest = 4'd7;
    step("bubble", 1'b0, 1'b0, 1'b1, d);
    step("after_bubble", 1'b0, 1'b0, 1'b0, rnd_fields());
    step("all_three", 1'b1, 1'b1, 1'b1, rnd_fields());
    step("bubble_flush_b2b_a", 1'b0, 1'b0, 1'b1, rnd_fields());
    step("bubble_flush_b2b_b", 1'b0, 1'b1, 1'b0, rnd_fields());
    step("reload", 1'b0, 1'b0, 1'b0, rnd_fields());
    step("freeze_before_rst", 1'b1, 1'b0, 1'b0, rnd_fields());
    drain();

    // Async reset mid-freeze, between edges
    @(posedge clk_in); #3 rst_n_in = 1'b0;
    #1 check("async_rst_mid_freeze", zero, 0);
    model_st = '0; model_cnt = 0;
    rst_n_in = 1'b1;

`ifdef ID_EX_BUBBLE_CNT_EN
    step("cnt_flush_bubble", 1'b0, 1'b1, 1'b1, rnd_fields());
    step("cnt_bubble", 1'b0, 1'b0, 1'b1, rnd_fields());
    drain();
    total++;
    if (int'(bubble_cnt_out) != 2) begin
      bad++;
      $display("FAIL cnt_two got=%0d exp=2", bubble_cnt_out);
    end
    for (int i = 0; i < 5; i++) step("cnt_sat", 1'b0, 1'b1, 1'b0, rnd_fields());
    drain();
    total++;
    if (int'(bubble_cnt_out) != 3) begin
      bad++;
      $display("FAIL cnt_sat got=%0d exp=3", bubble_cnt_out);
    end
`endif

    // Randomized traffic with biased control
    for (int i = 0; i < 300; i++) begin
      step("random", ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 4) == 0), rnd_fields());
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire

// File: doc/id_ex_reg.md
# id_ex_reg

Pipeline register between instruction decode (ID) and execute (EX) in the 32-bit ARM-subset core. It captures decoded control, operand values and register indices each cycle, and presents them to the EX stage and to the forwarding unit. The `src1_out`/`src2_out` indices it drives are the ones compared against the MEM and WB destinations. It supports pipeline freeze (memory wait), bubble insertion (load-use hazard) and flush (taken branch).

## Interface
**Parameters**
- `DATA_W`, 32: width of PC and register operand values.
- `CNT_W`, 16: width of the bubble counter (only with `ID_EX_BUBBLE_CNT_EN`).

**Ports**
- `clk_in` in 1: clock, rising edge.
- `rst_n_in` in 1: reset, asynchronous, active-low.
- `freeze_in` in 1: hold all outputs (memory stage waiting).
- `flush_in` in 1: taken branch in EX; kill the instruction being captured.
- `bubble_in` in 1: load-use hazard; insert a NOP instead of the ID instruction.
- `wb_en_in`, `mem_r_en_in`, `mem_w_en_in`, `b_in`, `s_in` in 1 each: decoded control bits.
- `exe_cmd_in` in 4: ALU command.
- `imm_in` in 1: operand 2 is an immediate.
- `pc_in` in DATA_W: PC+4 of the ID instruction.
- `val_rn_in`, `val_rm_in` in DATA_W: register file read data.
- `shift_operand_in` in 12; `signed_imm24_in` in 24.
- `dest_in`, `src1_in`, `src2_in` in 4: destination and source register indices.
- `status_in` in 4: NZCV flags.
- Each of the above has a registered `*_out` counterpart of identical width.
- `valid_out` out 1: EX holds a real instruction.
- `bubble_cnt_out` out CNT_W: bubble count (present only with the macro).

## Operation
- Register update on each rising `clk_in` uses this priority, evaluated top-down:
  1. **Freeze.** If `freeze_in`=1, every output register holds its value. `flush_in` and `bubble_in` are ignored that cycle. Upstream keeps `flush_in` asserted until freeze drops.
  2. **Flush or bubble.** If `flush_in` or `bubble_in` is 1, the block loads a NOP:
     - `wb_en`, `mem_r_en`, `mem_w_en`, `b`, `s` and `valid` are cleared to 0.
     - `exe_cmd`, `dest`, `src1` and `src2` are cleared to 0.
     - Data fields (pc, val_*, imm fields, status) are cleared to 0 as well; they are never left stale.
  3. **Load.** Otherwise all `*_out` take their `*_in` values and `valid_out` goes to 1.
- A NOP's `wb_en_out`=0, so it can never match a later forwarding comparison.
- `src1_out`/`src2_out` always correspond to the values in `val_rn_out`/`val_rm_out`.
- There is no combinational path from any input to any output.

## Timing
- Latency is 1 cycle from input to `*_out`.
- While reset is asserted (`rst_n_in`=0), all outputs, including `valid_out` and `bubble_cnt_out`, are 0 immediately, with no clock needed. The first load happens on the first rising edge after deassertion.
- If reset asserts mid-freeze, the outputs still clear, and freeze has no effect until reset deasserts.
- With `freeze_in`, `flush_in` and `bubble_in` all high in the same cycle, the outputs hold.
- With `flush_in` and `bubble_in` both high (no freeze), one NOP is loaded and the counter increments by 1.
- A consecutive bubble and flush produce back-to-back NOPs, with `valid_out`=0 on each.

## Configuration
- Macro: `ID_EX_BUBBLE_CNT_EN`.
- **When defined:**
  - `bubble_cnt_out` exists.
  - It increments by 1 on each non-frozen edge where a NOP is loaded.
  - It saturates at 2^CNT_W−1 and never wraps.
  - It is cleared only by reset.
- **When undefined:** the port and the counter logic are absent. All other behaviour is identical.

## Test plan
- **Reset:** drive all inputs to nonzero values (`dest_in`=4'hA, `wb_en_in`=1) with `rst_n_in`=0, toggling the clock. Expect every output 0 and `valid_out`=0. Then deassert reset; one edge later expect `dest_out`=4'hA, `valid_out`=1.
- **Load:** apply `val_rn_in`=32'h1234_5678, `src1_in`=3, `exe_cmd_in`=4'b0010. Next cycle expect `val_rn_out`=32'h1234_5678, `src1_out`=3, `exe_cmd_out`=4'b0010.
- **Freeze:** load an instruction with `dest_in`=5, then assert `freeze_in` for 3 cycles while the inputs change and `flush_in`=1. Expect `dest_out`=5 and `valid_out`=1 held for all 3 cycles.
- **Bubble:** apply `bubble_in`=1 with `wb_en_in`=1 and `dest_in`=7. Expect `wb_en_out`=0, `dest_out`=0, `valid_out`=0. The next un-bubbled edge loads normally.
- **Flush + bubble + counter** (macro defined):
  - Assert `flush_in` and `bubble_in` together, then `bubble_in` alone. Expect `bubble_cnt_out`=2 and 2 NOP cycles.
  - With CNT_W=2, force 5 NOPs. Expect `bubble_cnt_out` to saturate at 3.
- **Async reset mid-freeze:** pull `rst_n_in` low between clock edges while frozen. Expect the outputs to go to 0 within the same cycle, before the next edge.
